// File: rtl/kvs_vs_regex_scheduler_if.sv
// -----------------------------------------------------------------------------
// kvs_vs_regex_scheduler_if
//   Bundles the value stream, the per-engine input/result FIFO ports and the
//   in-order decision port of the regex engine scheduler.
//   Modports:
//     master : scheduler side (accepts beats, writes engines, pops results,
//              presents decisions)
//     slave  : environment side (upstream, engines and consumer)
//   Signals:
//     in_data/in_valid/in_last/in_ready  value beat stream
//     eng_data/eng_valid/eng_ready       per-engine input FIFO write port
//     res_match/res_valid/res_ready      per-engine result FIFO read port
//     found_loc/found_valid/found_ready  in-order match decision
// -----------------------------------------------------------------------------
interface kvs_vs_regex_scheduler_if #(
  parameter int ENGINE_COUNT = 16
);
  logic [511:0]            in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [511:0]            eng_data;
  logic [ENGINE_COUNT-1:0] eng_valid;
  logic [ENGINE_COUNT-1:0] eng_ready;
  logic [ENGINE_COUNT-1:0] res_match;
  logic [ENGINE_COUNT-1:0] res_valid;
  logic [ENGINE_COUNT-1:0] res_ready;
  logic                    found_loc;
  logic                    found_valid;
  logic                    found_ready;

  modport master (
    input  in_data, in_valid, in_last, eng_ready, res_match, res_valid, found_ready,
    output in_ready, eng_data, eng_valid, res_ready, found_loc, found_valid
  );

  modport slave (
    output in_data, in_valid, in_last, eng_ready, res_match, res_valid, found_ready,
    input  in_ready, eng_data, eng_valid, res_ready, found_loc, found_valid
  );
endinterface

// File: rtl/kvs_vs_regex_scheduler.sv
// -----------------------------------------------------------------------------
// kvs_vs_regex_scheduler
//   Dispatches multi-beat values round-robin to regex engines that have both
//   credit and input room, remembers the dispatch order in an order FIFO and
//   returns engine match decisions strictly in that order.
//   Ports:
//     clk  : sole clock
//     rst  : asynchronous active-high reset
//     bus  : kvs_vs_regex_scheduler_if.master (stream, engine and decision ports)
//   Optional feature (macro KVS_REGEX_SCHED_STATS_EN):
//     stat_values  [31:0] : number of engine selections (wraps)
//     stat_matches [31:0] : number of accepted decisions with found_loc=1 (wraps)
// -----------------------------------------------------------------------------
module kvs_vs_regex_scheduler #(
  parameter int ENGINE_COUNT = 16,
  parameter int ENGINE_BITS  = 4,
  parameter int CREDITS      = 4,
  parameter int ORDER_BITS   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  kvs_vs_regex_scheduler_if.master  bus
`ifdef KVS_REGEX_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_values,
  output logic [31:0]               stat_matches
`endif
);

  localparam int CW     = $clog2(CREDITS + 1);
  localparam int ODEPTH = 1 << ORDER_BITS;
  localparam int LAST_I = ENGINE_COUNT - 1;

  localparam logic [CW-1:0]           CRED_MAX  = CREDITS[CW-1:0];
  localparam logic [ENGINE_BITS-1:0]  LAST_ENG  = LAST_I[ENGINE_BITS-1:0];
  localparam logic [ORDER_BITS:0]     FIFO_FULL = ODEPTH[ORDER_BITS:0];
  localparam logic [ENGINE_COUNT-1:0] ONE_HOT0  = {{(ENGINE_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  state_r;
  logic [ENGINE_BITS-1:0]  rr_ptr_r;
  logic [ENGINE_BITS-1:0]  sel_r;
  logic [CW-1:0]           credit_r [ENGINE_COUNT];
  logic [ENGINE_BITS-1:0]  order_mem_r [ODEPTH];
  logic [ORDER_BITS-1:0]   wr_ptr_r;
  logic [ORDER_BITS-1:0]   rd_ptr_r;
  logic [ORDER_BITS:0]     count_r;

  int                      sum_s;
  int                      wrap_s;
  logic [ENGINE_BITS-1:0]  idx_s;
  logic                    hit_s;
  logic                    cand_ok_s;
  logic [ENGINE_BITS-1:0]  cand_s;
  logic [ENGINE_BITS-1:0]  rr_next_s;
  logic [ENGINE_BITS-1:0]  head_s;
  logic                    order_empty_s;
  logic                    order_full_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    beat_s;
  logic [ENGINE_COUNT-1:0] cred_inc_s;
  logic [ENGINE_COUNT-1:0] cred_dec_s;

  // Round-robin search from rr_ptr for the first engine with spare credit and input room
  always_comb begin
    sum_s     = 0;
    wrap_s    = 0;
    idx_s     = '0;
    hit_s     = 1'b0;
    cand_ok_s = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < ENGINE_COUNT; k++) begin
      sum_s     = int'(rr_ptr_r) + k;
      wrap_s    = (sum_s >= ENGINE_COUNT) ? (sum_s - ENGINE_COUNT) : sum_s;
      idx_s     = wrap_s[ENGINE_BITS-1:0];
      hit_s     = !cand_ok_s && (credit_r[idx_s] < CRED_MAX) && bus.eng_ready[idx_s];
      cand_s    = hit_s ? idx_s : cand_s;
      cand_ok_s = cand_ok_s || hit_s;
    end
  end

  assign rr_next_s = (cand_s == LAST_ENG) ? '0 : (cand_s + 1'b1);

  // Collect path is purely combinational so decisions add no latency
  assign order_empty_s   = (count_r == '0);
  assign order_full_s    = (count_r == FIFO_FULL);
  assign head_s          = order_mem_r[rd_ptr_r];
  assign bus.found_valid = !order_empty_s && bus.res_valid[head_s];
  // Gated with empty so a stale FIFO slot never leaks onto found_loc
  assign bus.found_loc   = !order_empty_s && bus.res_match[head_s];
  assign bus.res_ready   = (bus.found_ready && !order_empty_s) ? (ONE_HOT0 << head_s) : '0;
  assign pop_s           = bus.found_valid && bus.found_ready;

  // Dispatch path
  assign push_s        = (state_r == IDLE) && bus.in_valid && cand_ok_s && !order_full_s;
  assign bus.in_ready  = (state_r == STREAM) && bus.eng_ready[sel_r];
  assign beat_s        = bus.in_valid && bus.in_ready;
  assign bus.eng_data  = bus.in_data;
  assign bus.eng_valid = beat_s ? (ONE_HOT0 << sel_r) : '0;

  // Credit is taken at selection and returned when that engine's decision is accepted
  assign cred_inc_s = push_s ? (ONE_HOT0 << cand_s) : '0;
  assign cred_dec_s = pop_s ? (ONE_HOT0 << head_s) : '0;

  // Dispatch FSM: selects an engine in IDLE, streams beats to it in STREAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      sel_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (push_s) begin
            sel_r    <= cand_s;
            rr_ptr_r <= rr_next_s;
            state_r  <= STREAM;
          end else begin
            state_r  <= IDLE;
          end
        end
        STREAM: begin
          if (beat_s && bus.in_last) begin
            state_r <= IDLE;
          end else begin
            state_r <= STREAM;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Order FIFO storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (push_s) begin
      order_mem_r[wr_ptr_r] <= cand_s;
    end else begin
      order_mem_r[wr_ptr_r] <= order_mem_r[wr_ptr_r];
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Per-engine credit counters; a simultaneous take and return cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENGINE_COUNT; i++) credit_r[i] <= '0;
    end else begin
      for (int i = 0; i < ENGINE_COUNT; i++) begin
        case ({cred_inc_s[i], cred_dec_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] + 1'b1;
          2'b01:   credit_r[i] <= credit_r[i] - 1'b1;
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

`ifdef KVS_REGEX_SCHED_STATS_EN
  // Free-running statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_values  <= 32'd0;
      stat_matches <= 32'd0;
    end else begin
      if (push_s) stat_values <= stat_values + 32'd1;
      if (pop_s && bus.found_loc) stat_matches <= stat_matches + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kvs_vs_regex_scheduler.sv
// -----------------------------------------------------------------------------
// tb_kvs_vs_regex_scheduler
//   Self-checking bench: a transaction-level model (credit table, order queue,
//   round-robin pointer) predicts every output each cycle; directed scenarios
//   pin the model with literal expectations, then randomized traffic with an
//   engine/result scoreboard exercises the whole dispatch/collect loop.
// -----------------------------------------------------------------------------
module tb_kvs_vs_regex_scheduler;
  localparam int N     = 4;
  localparam int EB    = 2;
  localparam int C     = 2;
  localparam int OB    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kvs_vs_regex_scheduler_if #(.ENGINE_COUNT(N)) bus ();
`ifdef KVS_REGEX_SCHED_STATS_EN
  logic [31:0] stat_values;
  logic [31:0] stat_matches;
`endif

  kvs_vs_regex_scheduler #(
    .ENGINE_COUNT(N), .ENGINE_BITS(EB), .CREDITS(C), .ORDER_BITS(OB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef KVS_REGEX_SCHED_STATS_EN
    ,
    .stat_values(stat_values),
    .stat_matches(stat_matches)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model
  bit m_busy;
  int m_sel, m_rr;
  int m_cred [N];
  int m_order[$];
  int m_sel_cnt, m_match_cnt;

  // observation logs and last-cycle samples
  int            beat_eng_q[$];
  logic [511:0]  beat_data_q[$];
  int            found_log_q[$];
  int            want_q[$];
  logic          last_in_ready, last_found_valid, last_acc;
  logic [N-1:0]  last_eng_valid, last_res_ready;

  // random-phase traffic state
  bit rand_mode;
  bit have_val;
  int cur_len, cur_beat;
  bit cur_match;
  int exp_found[$];
  int res_eng_q[$];
  int res_val_q[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_res(input int e);
    for (int j = 0; j < res_eng_q.size(); j++) if (res_eng_q[j] == e) return j;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_sel = 0; m_rr = 0;
    for (int i = 0; i < N; i++) m_cred[i] = 0;
    m_order.delete(); m_sel_cnt = 0; m_match_cnt = 0;
    beat_eng_q.delete(); beat_data_q.delete(); found_log_q.delete();
    exp_found.delete(); res_eng_q.delete(); res_val_q.delete();
    have_val = 1'b0;
  endtask

  // called mid-cycle: predict, compare, then advance the model across the next edge
  task automatic check_cycle();
    logic [N-1:0] e_eng_valid, e_res_ready;
    logic e_in_ready, e_fv, e_fl;
    int head, cand, k_idx;
    bit pushing;
    head = (m_order.size() > 0) ? m_order[0] : 0;
    e_in_ready  = m_busy && bus.eng_ready[m_sel];
    e_eng_valid = '0;
    if (e_in_ready && bus.in_valid) e_eng_valid[m_sel] = 1'b1;
    e_fv = (m_order.size() > 0) && bus.res_valid[head];
    e_fl = (m_order.size() > 0) && bus.res_match[head];
    e_res_ready = '0;
    if (bus.found_ready && m_order.size() > 0) e_res_ready[head] = 1'b1;

    cmp("in_ready",    64'(bus.in_ready),    64'(e_in_ready));
    cmp("eng_valid",   64'(bus.eng_valid),   64'(e_eng_valid));
    cmp("res_ready",   64'(bus.res_ready),   64'(e_res_ready));
    cmp("found_valid", 64'(bus.found_valid), 64'(e_fv));
    cmp("found_loc",   64'(bus.found_loc),   64'(e_fl));
    cmp("eng_data",    64'(bus.eng_data === bus.in_data), 64'(1));

    last_in_ready = bus.in_ready; last_found_valid = bus.found_valid;
    last_eng_valid = bus.eng_valid; last_res_ready = bus.res_ready;
    last_acc = bus.in_valid && bus.in_ready;
    for (int i = 0; i < N; i++) if (bus.eng_valid[i]) begin
      beat_eng_q.push_back(i);
      beat_data_q.push_back(bus.eng_data);
    end
    if (bus.found_valid && bus.found_ready) found_log_q.push_back(int'(bus.found_loc));

    if (rand_mode) begin
      if (e_fv && bus.found_ready) begin
        if (exp_found.size() > 0) cmp("found_order", 64'(bus.found_loc), 64'(exp_found.pop_front()));
        else cmp("found_unexpected", 64'(1), 64'(0));
        k_idx = first_res(head);
        if (k_idx >= 0) begin res_eng_q.delete(k_idx); res_val_q.delete(k_idx); end
      end
      if (m_busy && bus.in_valid && e_in_ready) begin
        cur_beat++;
        if (bus.in_last) begin
          res_eng_q.push_back(m_sel); res_val_q.push_back(int'(cur_match)); have_val = 1'b0;
        end
      end
    end

    // selection uses pre-edge credits and pre-edge FIFO occupancy
    cand = -1;
    if (!m_busy && bus.in_valid)
      for (int k = 0; k < N; k++) begin
        int e;
        e = (m_rr + k) % N;
        if (cand < 0 && m_cred[e] < C && bus.eng_ready[e]) cand = e;
      end
    pushing = (cand >= 0) && (m_order.size() < DEPTH);

    if (e_fv && bus.found_ready) begin
      m_cred[head]--;
      void'(m_order.pop_front());
      if (e_fl) m_match_cnt++;
    end
    if (pushing) begin
      m_cred[cand]++; m_order.push_back(cand);
      m_sel = cand; m_rr = (cand + 1) % N; m_busy = 1'b1; m_sel_cnt++;
      if (rand_mode) exp_found.push_back(int'(cur_match));
    end else if (m_busy && bus.in_valid && e_in_ready && bus.in_last) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    bus.res_valid = '0; bus.res_match = '0; bus.found_ready = 1'b0;
    bus.eng_ready = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_value(input int n);
    int beat, cnt;
    beat = 0; cnt = 0;
    while (beat < n && cnt < 50) begin
      bus.in_valid = 1'b1;
      bus.in_last  = (beat == n - 1);
      tick();
      if (last_acc) beat++;
      cnt++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (cnt >= 50) cmp("send_timeout", 64'(beat), 64'(n));
  endtask

  task automatic check_engs(input string name);
    cmp({name, "_count"}, 64'(beat_eng_q.size()), 64'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < beat_eng_q.size(); i++)
      cmp(name, 64'(beat_eng_q[i]), 64'(want_q[i]));
  endtask

  task automatic drive_rand();
    if (!have_val) begin
      have_val = 1'b1; cur_len = $urandom_range(1, 4); cur_beat = 0;
      cur_match = 1'($urandom_range(0, 1));
    end
    bus.in_valid = ($urandom_range(0, 4) != 0);
    bus.in_last  = (cur_beat == cur_len - 1);
    for (int w = 0; w < 16; w++) bus.in_data[w*32 +: 32] = $urandom;
    bus.found_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < N; i++) begin
      int j;
      j = first_res(i);
      bus.eng_ready[i] = ($urandom_range(0, 9) < 8);
      bus.res_valid[i] = (j >= 0) && ($urandom_range(0, 2) != 0);
      bus.res_match[i] = (j >= 0) ? 1'(res_val_q[j]) : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rand_mode = 1'b0;
    idle_inputs();
    do_reset();

    // reset values at rest
    tick();
    cmp("rst_in_ready", 64'(last_in_ready), 64'(0));
    cmp("rst_res_ready", 64'(last_res_ready), 64'(0));

    // reordering: engines 0,1,2; results arrive 2,1,0
    do_reset();
    bus.found_ready = 1'b0;
    send_value(1); send_value(1); send_value(1);
    want_q = {0, 1, 2}; check_engs("reorder_eng");
    bus.found_ready = 1'b1;
    bus.res_valid = 4'b0100; bus.res_match = 4'b0100; tick();
    cmp("reorder_wait_e2", 64'(last_found_valid), 64'(0));
    cmp("reorder_head_pop", 64'(last_res_ready), 64'(4'b0001));
    bus.res_valid = 4'b0110; tick();
    cmp("reorder_wait_e1", 64'(last_found_valid), 64'(0));
    bus.res_valid = 4'b0111; bus.res_match = 4'b0101; tick();
    cmp("reorder_e0_valid", 64'(last_found_valid), 64'(1));
    bus.res_valid = 4'b0110; tick();
    bus.res_valid = 4'b0100; tick();
    bus.res_valid = 4'b0000; bus.found_ready = 1'b0; tick();
    want_q = {1, 0, 1};
    cmp("reorder_found_count", 64'(found_log_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < found_log_q.size(); i++)
      cmp("reorder_found", 64'(found_log_q[i]), 64'(want_q[i]));

    // backpressure: 4-beat value, engine 0 stalls during beat 2
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 512'(32'hB001); tick();
    cmp("bp_select_cycle", 64'(last_in_ready), 64'(0));
    tick();
    bus.in_data = 512'(32'hB002); bus.eng_ready[0] = 1'b0; tick();
    cmp("bp_stall_in_ready", 64'(last_in_ready), 64'(0));
    cmp("bp_stall_eng_valid", 64'(last_eng_valid), 64'(0));
    bus.eng_ready[0] = 1'b1; tick();
    bus.in_data = 512'(32'hB003); tick();
    bus.in_data = 512'(32'hB004); bus.in_last = 1'b1; tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; tick();
    cmp("bp_back_to_idle", 64'(last_in_ready), 64'(0));
    want_q = {0, 0, 0, 0}; check_engs("bp_eng");
    for (int i = 0; i < 4 && i < beat_data_q.size(); i++)
      cmp("bp_beat_data", 64'(beat_data_q[i][31:0]), 64'(32'hB001 + i));

    // skip and wrap: engine 1 never ready
    do_reset();
    bus.eng_ready = 4'b1101;
    send_value(1); send_value(1); send_value(1); send_value(1);
    want_q = {0, 2, 3, 0}; check_engs("skip_wrap_eng");

    // credit exhaustion with only engines 0 and 1 available
    do_reset();
    bus.eng_ready = 4'b0011;
    send_value(1); send_value(1); send_value(1); send_value(1);
    want_q = {0, 1, 0, 1}; check_engs("credit_eng");
    bus.in_valid = 1'b1; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("credit_blocked", 64'({last_in_ready, last_eng_valid}), 64'(0));
    end
    bus.res_valid = 4'b0001; bus.res_match = 4'b0001; bus.found_ready = 1'b1; tick();
    cmp("credit_return", 64'(last_found_valid), 64'(1));
    bus.res_valid = 4'b0000; bus.found_ready = 1'b0; tick();
    cmp("credit_select_cycle", 64'(last_in_ready), 64'(0));
    tick();
    cmp("credit_5th_ready", 64'(last_in_ready), 64'(1));
    cmp("credit_5th_engine", 64'(last_eng_valid), 64'(4'b0001));
    bus.in_valid = 1'b0; bus.in_last = 1'b0;

    // asynchronous reset in the middle of a value
    do_reset();
    send_value(1);
    bus.in_valid = 1'b1; bus.in_last = 1'b0; tick();
    bus.found_ready = 1'b1; bus.res_valid = 4'b0001; bus.res_match = 4'b0001;
    #2;
    cmp("pre_rst_in_ready", 64'(bus.in_ready), 64'(1));
    cmp("pre_rst_found_valid", 64'(bus.found_valid), 64'(1));
    cmp("pre_rst_res_ready", 64'(bus.res_ready), 64'(4'b0001));
    rst = 1'b1;
    #1;
    cmp("async_rst_outputs",
        64'({bus.in_ready, bus.eng_valid, bus.res_ready, bus.found_valid, bus.found_loc}), 64'(0));
`ifdef KVS_REGEX_SCHED_STATS_EN
    cmp("async_rst_stats", 64'({stat_values, stat_matches}), 64'(0));
`endif
    @(posedge clk); #1;
    idle_inputs(); model_reset();
    rst = 1'b0;
    bus.eng_ready = 4'b0001;
    send_value(1); send_value(1);
    want_q = {0, 0}; check_engs("rst_credits_clear");

    // randomized traffic against the model and the result scoreboard
    do_reset();
    rand_mode = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_rand();
      tick();
    end
    rand_mode = 1'b0;
`ifdef KVS_REGEX_SCHED_STATS_EN
    cmp("stat_values", 64'(stat_values), 64'(m_sel_cnt));
    cmp("stat_matches", 64'(stat_matches), 64'(m_match_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
